shift_tx_scheduler: RTL and testbench
=====================================

Name: shift_tx_scheduler

Overview:
Arbitrated parallel-to-serial transmit controller built around an internal W-bit left-shift register.
- Two requesters offer parallel words over a valid/ready handshake.
- A round-robin arbiter grants one word at a time. The block loads the word and sequences it out MSB-first, one bit per shift_en tick.
- Sits between byte-producing logic and a serial line driver, pacing the shift register that today is driven free-running.

Parameters:
W, 8, data word width in bits (>=2)
GAP, 1, number of shift_en ticks of idle line between frames (0 = back-to-back allowed)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
shift_en  input  1  bit-rate tick; shifting and gap counting advance only when high
req_valid  input  2  per-requester word valid
req_data  input  2*W  requester i word in bits [i*W +: W]
req_ready  output  2  per-requester accept (combinational, one-hot or zero)
ser_out  output  1  serial data, MSB first
ser_valid  output  1  high while a frame bit is on ser_out
frame_start  output  1  high during the first bit period of a frame
last_bit  output  1  high during the final bit period of a frame
busy  output  1  high in any state other than IDLE
grant_id  output  1  requester index of the frame in flight / last served

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, shreg=0, bit counter=0, gap counter=0, rr pointer=1 (requester 0 has priority first), grant_id=0. Outputs: ser_out=0, ser_valid=0, frame_start=0, last_bit=0, busy=0, req_ready=0. Reset overrides everything, including mid-frame; the in-flight word is discarded.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - If any req_valid is set, assert req_ready for the granted index in the same cycle. Acceptance does not wait for shift_en.
  - Grant rule: if only one requester is valid, grant it. If both are valid, grant the index != rr pointer's last-served.
  - On that edge: shreg<=req_data[grant], grant_id<=grant, rr pointer<=grant, bitcnt<=0, state<=SHIFT.
- SHIFT:
  - ser_valid=1; ser_out=shreg[W-1].
  - frame_start=(bitcnt==0); last_bit=(bitcnt==W-1).
  - When shift_en=1: shreg<=shreg<<1 (zero fill) and bitcnt++.
  - If shift_en=1 with bitcnt==W-1, go to GAP (GAP>0, gapcnt<=0) or IDLE (GAP==0).
  - While shift_en=0, all outputs hold. Each bit therefore lasts exactly one shift_en tick.
- GAP:
  - ser_out=0, ser_valid=0, req_ready=0.
  - gapcnt increments on shift_en; when shift_en=1 and gapcnt==GAP-1, go to IDLE.
- Outside SHIFT: ser_out=0, frame_start=0, last_bit=0.
- req_ready is only ever asserted in IDLE, so requesters must hold valid/data until ready. Dropping valid before grant is allowed (no request is latched).
- Minimum frame-to-frame spacing with continuous shift_en: W + GAP + 1 cycles (the +1 is the IDLE accept cycle).
- bitcnt width: $clog2(W). gapcnt width: $clog2(GAP+1), minimum 1.

Decomposition:
- Shared package shift_tx_pkg: state enum (IDLE, SHIFT, GAP), default width constant, requester-count constant (2).
- One sub-module: rr_arb2 (2-input round-robin arbiter; inputs valid[1:0] and last-served; outputs one-hot grant and index). Pointer update stays in the parent.

Test Plan:
1. Reset, then req_valid=01, data0=0xA5, shift_en=1 continuously.
   - req_ready=01 for one cycle.
   - ser_out over the next 8 cycles = 1,0,1,0,0,1,0,1.
   - frame_start on bit 1 only, last_bit on bit 8 only.
   - GAP=1 idle cycle follows, then busy=0.
2. Both valid continuously: data0=0x0F, data1=0xF0.
   - Frames alternate 0x0F, 0xF0, 0x0F.
   - grant_id alternates 0,1,0; req_ready is never 11.
3. shift_en asserted every 3rd cycle, data=0x81.
   - Each bit is held for exactly 3 cycles.
   - ser_out=1 for the first 3 cycles, 0 for 18 cycles, 1 for 3 cycles.
4. GAP=0, req1 continuously valid with data 0xFF.
   - Frames are separated by exactly one ser_valid=0 cycle (IDLE accept).
5. rst pulsed during bit 4 of 0xC3.
   - Next cycle: ser_valid=0, busy=0, ser_out=0.
   - A fresh request from both requesters is granted to requester 0.
6. Valid raised then dropped during SHIFT of another frame.
   - No req_ready is asserted for it; the word is not transmitted.

Source files
------------

// File: rtl/shift_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | shift_tx_pkg: shared types/constants for shift_tx_scheduler    |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package shift_tx_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DEFAULT_W = 8;
  localparam int NUM_REQ   = 2;
endpackage
`default_nettype wire

// File: rtl/shift_tx_scheduler_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------+
// | rr_arb2: two-input round-robin arbiter (pointer kept by parent)|
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module rr_arb2
  import shift_tx_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               last,
  output logic [NUM_REQ-1:0] grant,
  output logic               idx
);
  always_comb begin
    idx   = 1'b0;
    grant = '0;
    // On contention the requester not served last time wins.
    if (valid == 2'b11) begin
      idx = ~last;
    end else begin
      idx = valid[1];
    end
    if (|valid) begin
      grant = idx ? 2'b10 : 2'b01;
    end
  end
endmodule
`default_nettype wire

// File: rtl/shift_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------+
// | shift_tx_scheduler: arbitrated MSB-first parallel-to-serial TX |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module shift_tx_scheduler
  import shift_tx_pkg::*;
#(
  parameter int W   = DEFAULT_W,
  parameter int GAP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   shift_en,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*W-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   ser_out,
  output logic                   ser_valid,
  output logic                   frame_start,
  output logic                   last_bit,
  output logic                   busy,
  output logic                   grant_id
);
  localparam int BW = $clog2(W);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t               state;
  state_t               state_nxt;
  logic [W-1:0]         shreg;
  logic [BW-1:0]        bitcnt;
  logic [GW-1:0]        gapcnt;
  logic                 rr_last;
  logic [NUM_REQ-1:0]   arb_grant;
  logic                 arb_idx;

  rr_arb2 u_arb (
    .valid (req_valid),
    .last  (rr_last),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    last_bit    = 1'b0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        // Ready is masked during reset: no word is taken on a reset edge.
        req_ready = rst ? '0 : arb_grant;
        if (|req_valid) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ser_valid   = 1'b1;
        ser_out     = shreg[W-1];
        frame_start = (bitcnt == '0);
        last_bit    = (bitcnt == BIT_LAST);
        if (shift_en && (bitcnt == BIT_LAST)) begin
          state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (shift_en && (gapcnt == GAP_LAST)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      bitcnt   <= '0;
      gapcnt   <= '0;
      rr_last  <= 1'b1;
      grant_id <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            shreg    <= arb_idx ? req_data[2*W-1:W] : req_data[W-1:0];
            grant_id <= arb_idx;
            rr_last  <= arb_idx;
            bitcnt   <= '0;
          end
        end
        ST_SHIFT: begin
          if (shift_en) begin
            shreg  <= {shreg[W-2:0], 1'b0};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == BIT_LAST) begin
              gapcnt <= '0;
            end
          end
        end
        ST_GAP: begin
          if (shift_en) begin
            gapcnt <= gapcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_shift_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_shift_tx_scheduler: scoreboard bench for shift_tx_scheduler |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module tb_shift_tx_scheduler;
  localparam int W   = 8;
  localparam int GAP = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           shift_en;
  logic [1:0]     req_valid;
  logic [2*W-1:0] req_data;
  logic [1:0]     req_ready;
  logic           ser_out, ser_valid, frame_start, last_bit, busy, grant_id;

  shift_tx_scheduler #(.W(W), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .shift_en(shift_en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start),
    .last_bit(last_bit), .busy(busy), .grant_id(grant_id)
  );

  // Second instance with no inter-frame gap, requester 1 always pending.
  logic           rst0;
  logic           se0 = 1'b1;
  logic [1:0]     v0 = 2'b10;
  logic [2*W-1:0] d0 = 16'hFF00;
  logic [1:0]     ready0;
  logic           so0, sv0, fs0, lb0, busy0, gid0;

  shift_tx_scheduler #(.W(W), .GAP(0)) dut0 (
    .clk(clk), .rst(rst0), .shift_en(se0),
    .req_valid(v0), .req_data(d0), .req_ready(ready0),
    .ser_out(so0), .ser_valid(sv0), .frame_start(fs0),
    .last_bit(lb0), .busy(busy0), .grant_id(gid0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: after an accept the line stays busy for exactly
  // W+GAP shift_en ticks, the first W of which carry frame bits.
  int          m_ticks;
  bit          m_last;
  bit [1:0]    acc;
  bit [1:0]    pend;
  logic [W-1:0] dat [2];
  bit          exp_chk = 1'b0;
  bit [1:0]    exp_ready;
  bit          exp_busy, exp_sv;
  bit [W:0]    exp_q [$];

  int se_mode, se_phase;
  bit auto_rr, rand_new, rand_drop;
  bit dut0_done = 1'b0;

  task automatic do_cycle(input bit r);
    bit g;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) pend[i] = auto_rr;
      if (rand_new && !pend[i] && $urandom_range(3) == 0) begin
        pend[i] = 1'b1;
        dat[i]  = W'($urandom);
      end
      if (rand_drop && pend[i] && m_ticks != 0 && $urandom_range(5) == 0) pend[i] = 1'b0;
    end
    case (se_mode)
      0: shift_en = 1'b1;
      1: begin
        shift_en = (se_phase == 0);
        se_phase = (se_phase + 1) % 3;
      end
      default: shift_en = 1'($urandom_range(1));
    endcase
    rst       = r;
    req_valid = pend;
    req_data  = {dat[1], dat[0]};
    acc       = 2'b00;
    if (r) begin
      exp_chk = 1'b0;
      m_ticks = 0;
      m_last  = 1'b1;
    end else begin
      exp_chk   = 1'b1;
      exp_busy  = (m_ticks != 0);
      exp_sv    = (m_ticks > GAP);
      exp_ready = 2'b00;
      if (m_ticks == 0) begin
        if (pend != 2'b00) begin
          g = (pend == 2'b11) ? !m_last : pend[1];
          acc[g]    = 1'b1;
          exp_ready = acc;
          exp_q.push_back({g, dat[g]});
          m_last  = g;
          m_ticks = W + GAP;
        end
      end else if (shift_en) begin
        m_ticks--;
      end
    end
  endtask

  // Monitor: per-cycle handshake checks and frame reassembly.
  int           bit_idx = 0;
  logic [W-1:0] word;
  bit [W:0]     e;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      bit_idx = 0;
    end else if (exp_chk) begin
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, exp_busy);
      check("ser_valid", ser_valid, exp_sv);
      if (ser_valid) begin
        check("frame_start", frame_start, bit_idx == 0);
        check("last_bit", last_bit, bit_idx == W - 1);
        if (shift_en) begin
          word = {word[W-2:0], ser_out};
          bit_idx++;
          if (bit_idx == W) begin
            bit_idx = 0;
            if (exp_q.size() == 0) begin
              check("frame_unexpected", word, 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check("frame_data", word, e[W-1:0]);
              check("frame_gid", grant_id, e[W]);
            end
          end
        end
      end else begin
        check("idle_lines", {ser_out, frame_start, last_bit}, 0);
      end
    end
  end

  // Zero-gap instance: one IDLE accept cycle between back-to-back frames.
  initial begin
    bit sv;
    rst0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      sv = (k % 9 != 0);
      check("g0_ser_valid", sv0, sv);
      check("g0_req_ready", ready0, sv ? 2'b00 : 2'b10);
      check("g0_ser_out", so0, sv);
    end
    dut0_done = 1'b1;
  end

  initial begin
    rst = 1'b1; shift_en = 1'b0; req_valid = '0; req_data = '0;
    pend = '0; acc = '0; m_ticks = 0; m_last = 1'b1;
    auto_rr = 0; rand_new = 0; rand_drop = 0; se_mode = 0; se_phase = 0;
    dat[0] = '0; dat[1] = '0;
    repeat (3) do_cycle(1'b1);
    do_cycle(1'b0);
    @(negedge clk);
    check("reset_outputs", {ser_out, ser_valid, frame_start, last_bit, busy, req_ready, grant_id}, 0);

    // Single requester, continuous shift_en.
    pend[0] = 1'b1; dat[0] = 8'hA5;
    repeat (12) do_cycle(1'b0);

    // Both requesters held valid from reset: alternation 0,1,0,...
    do_cycle(1'b1);
    dat[0] = 8'h0F; dat[1] = 8'hF0; pend = 2'b11; auto_rr = 1'b1;
    repeat (3 * (W + GAP + 1) + 2) do_cycle(1'b0);
    auto_rr = 1'b0;
    repeat (30) do_cycle(1'b0);

    // shift_en every third cycle.
    se_mode = 1; se_phase = 0;
    pend[0] = 1'b1; dat[0] = 8'h81;
    repeat (3 * (W + GAP) + 6) do_cycle(1'b0);
    se_mode = 0;

    // Reset during bit 4, then both request: requester 0 wins.
    pend[0] = 1'b1; dat[0] = 8'hC3;
    repeat (4) do_cycle(1'b0);
    do_cycle(1'b1);
    pend = 2'b11; dat[0] = 8'h11; dat[1] = 8'h22;
    do_cycle(1'b0);
    @(negedge clk);
    check("post_reset", {ser_valid, busy, ser_out, req_ready}, 4'b0001);
    repeat (30) do_cycle(1'b0);

    // Request raised and withdrawn while another frame is shifting.
    pend[0] = 1'b1; dat[0] = 8'h3C;
    repeat (2) do_cycle(1'b0);
    pend[1] = 1'b1; dat[1] = 8'h99;
    repeat (3) do_cycle(1'b0);
    pend[1] = 1'b0;
    repeat (12) do_cycle(1'b0);

    // Randomized traffic with sporadic resets.
    rand_new = 1; rand_drop = 1; se_mode = 2;
    for (int n = 0; n < 3000; n++) do_cycle(n % 997 == 500);
    rand_new = 0; rand_drop = 0; se_mode = 0;
    repeat (40) do_cycle(1'b0);
    @(negedge clk);
    check("frames_outstanding", exp_q.size(), 0);
    check("gap0_checker_done", dut0_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
